// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and helpers for the iterative multiply/divide unit
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_t;

  // Iteration counter width; it must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// rtl/multdiv_addsub.sv - WIDTH+1-bit adder/subtractor shared by the iterations and FIX negation
module multdiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  input  logic           cin,
  output logic [WIDTH:0] sum,
  output logic           cout
);

  logic [WIDTH:0] b_eff;

  // Subtraction inverts b; the caller supplies the +1 through cin so the same
  // cell can also form ~x + carry for the high half of a double-width negation.
  always_comb begin
    b_eff       = sub ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{(WIDTH + 1){1'b0}}, cin};
  end

endmodule

// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - one-bit-per-cycle signed/unsigned multiply and divide unit
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_inputRDY,
  output logic             data_resultRDY
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};

  state_t             state, state_nxt;
  op_t                op;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
  logic               sgn_mode;
  logic               sgn_q;      // product / quotient sign
  logic               sgn_r;      // remainder sign
  logic               div0;
  logic               exc_div;

  logic [WIDTH-1:0]   acc_lo, acc_hi;
  logic               start;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;

  logic [WIDTH:0]     main_a, main_b, main_sum;
  logic               main_sub, main_cin, main_cout;
  logic [WIDTH:0]     hi_sum;
  logic               hi_cin, hi_cout;
  logic               unused_hi;

  logic [2*WIDTH-1:0] acc_calc;
  logic [WIDTH-1:0]   fix_lo, fix_hi;
  logic               fix_exc;

  assign acc_lo        = acc[WIDTH-1:0];
  assign acc_hi        = acc[2*WIDTH-1:WIDTH];
  assign data_inputRDY = (state == IDLE);
  assign start         = (ctrl_MULT | ctrl_DIV) & (state == IDLE);
  assign neg_a         = ctrl_signed & data_operandA[WIDTH-1];
  assign neg_b         = ctrl_signed & data_operandB[WIDTH-1];
  assign mag_a         = neg_a ? -data_operandA : data_operandA;
  assign mag_b         = neg_b ? -data_operandB : data_operandB;

  multdiv_addsub #(.WIDTH(WIDTH)) u_main (
    .a    (main_a),
    .b    (main_b),
    .sub  (main_sub),
    .cin  (main_cin),
    .sum  (main_sum),
    .cout (main_cout)
  );

  // High-half negation: ~hi + carry, the carry coming from the low half for a product.
  multdiv_addsub #(.WIDTH(WIDTH)) u_hi (
    .a    ({(WIDTH + 1){1'b0}}),
    .b    ({1'b0, acc_hi}),
    .sub  (1'b1),
    .cin  (hi_cin),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  assign unused_hi = ^{hi_sum[WIDTH], hi_cout};

  // Shared adder operand select: iteration step in CALC, low-half negation otherwise.
  always_comb begin
    main_a   = {(WIDTH + 1){1'b0}};
    main_b   = {1'b0, acc_lo};
    main_sub = 1'b1;
    main_cin = 1'b1;
    hi_cin   = (op == OP_MULT) ? main_cout : 1'b1;
    if (state == CALC) begin
      if (op == OP_MULT) begin
        main_a   = {1'b0, acc_hi};
        main_b   = {1'b0, opnd};
        main_sub = 1'b0;
        main_cin = 1'b0;
      end else begin
        main_a   = {acc_hi, acc_lo[WIDTH-1]};
        main_b   = {1'b0, opnd};
        main_sub = 1'b1;
        main_cin = 1'b1;
      end
    end
  end

  // Next accumulator for one shift-add or one restoring-division step.
  always_comb begin
    acc_calc = acc;
    if (op == OP_MULT) begin
      if (acc_lo[0]) acc_calc = {main_sum, acc_lo[WIDTH-1:1]};
      else           acc_calc = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    end else begin
      if (main_cout) acc_calc = {main_sum[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
      else           acc_calc = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1], acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and exception decode for the FIX cycle.
  always_comb begin
    fix_lo  = acc_lo;
    fix_hi  = acc_hi;
    fix_exc = 1'b0;
    if (op == OP_MULT) begin
      if (sgn_q) begin
        fix_lo = main_sum[WIDTH-1:0];
        fix_hi = hi_sum[WIDTH-1:0];
      end
      if (sgn_mode) fix_exc = (fix_hi != {WIDTH{fix_lo[WIDTH-1]}});
      else          fix_exc = (fix_hi != {WIDTH{1'b0}});
    end else begin
      // A zero divisor leaves all-ones / |A|; only the remainder is re-signed back to A.
      if (sgn_q && !div0) fix_lo = main_sum[WIDTH-1:0];
      if (sgn_r)          fix_hi = hi_sum[WIDTH-1:0];
      fix_exc = exc_div;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_MULT | ctrl_DIV) state_nxt = CALC;
      CALC:    if (cnt == LAST_ITER) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand load, iteration datapath and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op             <= OP_MULT;
      cnt            <= '0;
      acc            <= '0;
      opnd           <= '0;
      sgn_mode       <= 1'b0;
      sgn_q          <= 1'b0;
      sgn_r          <= 1'b0;
      div0           <= 1'b0;
      exc_div        <= 1'b0;
      data_result    <= '0;
      data_result_hi <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            sgn_mode <= ctrl_signed;
            sgn_q    <= neg_a ^ neg_b;
            if (ctrl_MULT) begin
              op      <= OP_MULT;
              opnd    <= mag_a;
              acc     <= {{WIDTH{1'b0}}, mag_b};
              sgn_r   <= 1'b0;
              div0    <= 1'b0;
              exc_div <= 1'b0;
            end else begin
              op      <= OP_DIV;
              opnd    <= mag_b;
              acc     <= {{WIDTH{1'b0}}, mag_a};
              sgn_r   <= neg_a;
              div0    <= (data_operandB == {WIDTH{1'b0}});
              exc_div <= (data_operandB == {WIDTH{1'b0}}) |
                         (ctrl_signed && data_operandA == MIN_VAL &&
                          data_operandB == {WIDTH{1'b1}});
            end
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          acc <= acc_calc;
        end
        FIX: begin
          data_result    <= fix_lo;
          data_result_hi <= fix_hi;
          data_exception <= fix_exc;
          data_resultRDY <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// tb/tb_multdiv_iter.sv - directed self-checking bench for multdiv_iter at WIDTH=32
module tb_multdiv_iter;

  logic        clock;
  logic        resetn;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV, ctrl_signed;
  logic [31:0] data_result, data_result_hi;
  logic        data_exception, data_inputRDY, data_resultRDY;

  int checks   = 0;
  int failures = 0;

  multdiv_iter #(.WIDTH(32)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .ctrl_signed    (ctrl_signed),
    .data_result    (data_result),
    .data_result_hi (data_result_hi),
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a start now (at #1 after an edge) and count edges until the result pulse.
  task automatic run_op(input logic m, input logic d, input logic s,
                        input logic [31:0] a, input logic [31:0] b, output int lat);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    ctrl_signed   = s;
    data_operandA = a;
    data_operandB = b;
    lat = 0;
    while (lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      if (data_resultRDY) break;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (data_result !== 32'h0 || data_result_hi !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got %h/%h want 0/0", data_result, data_result_hi);
    end
    checks++;
    if (data_exception !== 1'b0 || data_resultRDY !== 1'b0 || data_inputRDY !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags got exc=%b rdy=%b in=%b want 0 0 1",
               data_exception, data_resultRDY, data_inputRDY);
    end
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_arith();
    logic        m [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    logic        s [8] = '{1, 1, 0, 1, 0, 0, 1, 1};
    logic [31:0] a [8] = '{32'd7, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                           32'd100, 32'd5, 32'h80000000, 32'hFFFFFFFB};
    logic [31:0] b [8] = '{32'hFFFFFFFD, 32'd2, 32'hFFFFFFFF, 32'd2,
                           32'd7, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [31:0] el[8] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD,
                           32'd14, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] eh[8] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                           32'd2, 32'd5, 32'h0, 32'hFFFFFFFB};
    logic        ee[8] = '{0, 1, 1, 0, 0, 1, 1, 1};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(m[i], !m[i], s[i], a[i], b[i], lat);
      checks++;
      if (lat !== 34) begin
        failures++;
        $display("FAIL arith%0d_latency got %0d want 34", i, lat);
      end
      checks++;
      if (data_result !== el[i] || data_result_hi !== eh[i] || data_exception !== ee[i]) begin
        failures++;
        $display("FAIL arith%0d_value got %h/%h exc=%b want %h/%h exc=%b", i,
                 data_result, data_result_hi, data_exception, el[i], eh[i], ee[i]);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_busy_ignore();
    int pulses = 0, first_at = 0, low = 0;
    ctrl_MULT = 1'b1; ctrl_signed = 1'b1;
    data_operandA = 32'd7; data_operandB = 32'hFFFFFFFD;
    for (int n = 1; n <= 36; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) ctrl_MULT = 1'b0;
      if (n == 5) begin
        ctrl_DIV = 1'b1; ctrl_signed = 1'b0;
        data_operandA = 32'd100; data_operandB = 32'd7;
      end
      if (n == 6) ctrl_DIV = 1'b0;
      if (!data_inputRDY) low++;
      if (data_resultRDY) begin
        pulses++;
        if (first_at == 0) first_at = n;
      end
    end
    checks++;
    if (pulses !== 1 || first_at !== 34) begin
      failures++;
      $display("FAIL busy_pulse got pulses=%0d at=%0d want 1 at 34", pulses, first_at);
    end
    checks++;
    if (low !== 33) begin
      failures++;
      $display("FAIL busy_inputrdy_low got %0d want 33", low);
    end
    checks++;
    if (data_result !== 32'hFFFFFFEB || data_result_hi !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL busy_result got %h/%h want ffffffeb/ffffffff", data_result, data_result_hi);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(1'b1, 1'b0, 1'b0, 32'd3, 32'd5, lat);
    checks++;
    if (lat !== 34 || data_result !== 32'd15 || data_inputRDY !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d res=%h in=%b want 34 0000000f 1",
               lat, data_result, data_inputRDY);
    end
    run_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, lat);
    checks++;
    if (lat !== 34 || data_result !== 32'd14 || data_result_hi !== 32'd2) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d res=%h/%h want 34 0000000e/00000002",
               lat, data_result, data_result_hi);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_both_starts();
    int lat;
    run_op(1'b1, 1'b1, 1'b0, 32'd6, 32'd7, lat);
    checks++;
    if (lat !== 34 || data_result !== 32'd42 || data_result_hi !== 32'd0) begin
      failures++;
      $display("FAIL both_starts got lat=%0d res=%h/%h want 34 0000002a/00000000",
               lat, data_result, data_result_hi);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    int lat;
    ctrl_MULT = 1'b1; ctrl_signed = 1'b0;
    data_operandA = 32'd9; data_operandB = 32'd9;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (data_result !== 32'h0 || data_result_hi !== 32'h0 || data_inputRDY !== 1'b1) begin
      failures++;
      $display("FAIL abort_outputs got %h/%h in=%b want 0/0 1",
               data_result, data_result_hi, data_inputRDY);
    end
    @(posedge clock);
    #1;
    resetn = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL abort_no_pulse got %0d pulses want 0", pulses);
    end
    run_op(1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, lat);
    checks++;
    if (lat !== 34 || data_result !== 32'hFFFFFFFD || data_result_hi !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL abort_next_op got lat=%0d res=%h/%h want 34 fffffffd/ffffffff",
               lat, data_result, data_result_hi);
    end
  endtask

  initial begin
    resetn = 1'b0;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; ctrl_signed = 1'b0;
    data_operandA = '0; data_operandB = '0;
    test_reset();
    test_arith();
    test_busy_ignore();
    test_back_to_back();
    test_both_starts();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_iter.md
# multdiv_iter

Parametrised iterative multiply/divide unit for the pipeline processor's execute stage. It replaces the combinational Booth tree and unrolled divider with a one-bit-per-cycle shared datapath. Operands and result are WIDTH bits, with signed/unsigned modes, a full double-width product, a division remainder, and a registered start/done handshake. The pipeline stalls on `data_inputRDY` and `data_resultRDY` exactly as before.

## Interface
- `WIDTH`, default 32: operand/result width; legal range 4..64.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `data_operandA`  in  WIDTH  multiplicand / dividend; sampled only on an accepted start.
- `data_operandB`  in  WIDTH  multiplier / divisor; sampled only on an accepted start.
- `ctrl_MULT`  in  1  start multiply; one-cycle pulse.
- `ctrl_DIV`  in  1  start divide; one-cycle pulse.
- `ctrl_signed`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the start.
- `data_result`  out  WIDTH  product low half / quotient.
- `data_result_hi`  out  WIDTH  product high half / remainder.
- `data_exception`  out  1  overflow or divide-by-zero for the last operation.
- `data_inputRDY`  out  1  unit idle; a start is accepted this cycle.
- `data_resultRDY`  out  1  one-cycle pulse; results valid.

## Operation
- States:
  - IDLE: `data_inputRDY` = 1.
  - CALC: WIDTH iterations.
  - FIX: sign correction and output register.
- IDLE→CALC on a start edge.
  - Both starts high: MULT wins.
  - A start is accepted only in IDLE; starts in CALC/FIX are ignored.
- Load on accept:
  - In signed mode, take the magnitude of each operand and latch the result sign.
    - Multiply: sign = A[W-1]^B[W-1].
    - Divide: quotient sign = A^B; remainder sign = sign of A.
  - Clear the iteration counter ($clog2(WIDTH+1) bits).
- Multiply: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per CALC cycle.
- Divide: restoring division, one quotient bit per CALC cycle, WIDTH+1-bit partial remainder.
- FIX:
  - Negate the product (2·WIDTH), quotient or remainder as the latched signs require.
  - Register all outputs.
  - Pulse `data_resultRDY`.
  - Return to IDLE.
- Exceptions:
  - Multiply, signed: set when the full product is not the sign-extension of its low WIDTH bits.
  - Multiply, unsigned: set when the high half is nonzero.
  - Divide by zero: quotient = all ones, remainder = dividend A unmodified, exception = 1. Completes with normal latency.
  - Signed MIN / -1: quotient = MIN, remainder = 0, exception = 1.
- `data_result`, `data_result_hi` and `data_exception` hold their values until the next FIX.

## Timing
- Reset: state = IDLE, all data outputs = 0, `data_exception` = 0, `data_resultRDY` = 0, `data_inputRDY` = 1.
- Reset mid-operation aborts immediately, with no result pulse.
- Start accepted at edge 0; CALC occupies edges 1..WIDTH; FIX occupies edge WIDTH+1.
  - `data_resultRDY` is high for the single cycle after edge WIDTH+1.
  - Latency is WIDTH+1 cycles; the same for every operation, including exceptions.
- `data_inputRDY` is decoded combinationally from state IDLE. It is high in the `data_resultRDY` cycle, so back-to-back operations issue with a WIDTH+2 cycle period.
- `data_inputRDY` is low for exactly WIDTH+1 cycles after an accept.

## Structure
- Shared package `multdiv_pkg`:
  - state enum (IDLE, CALC, FIX).
  - op enum (OP_MULT, OP_DIV).
  - function returning the counter width.
- Sub-module `multdiv_addsub`: a WIDTH+1-bit add/subtract used by both the multiply and divide iterations, plus the FIX negation via a sub/carry-in select.
- Everything else lives in the top module: FSM, counter, accumulator/remainder shift registers, sign latches.

## Test plan
All values at WIDTH=32.
- Signed multiply 7 × -3: after 33 cycles, result = 0xFFFFFFEB, hi = 0xFFFFFFFF, exception = 0, one `data_resultRDY` pulse.
- Signed 0x7FFFFFFF × 2: result = 0xFFFFFFFE, hi = 0x00000000, exception = 1. Unsigned 0xFFFFFFFF × 0xFFFFFFFF: result = 0x00000001, hi = 0xFFFFFFFE, exception = 1.
- Signed -7 / 2: quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF. Unsigned 100 / 7: quotient = 14, remainder = 2.
- Divide by zero, 5 / 0: quotient = 0xFFFFFFFF, remainder = 5, exception = 1. Signed 0x80000000 / -1: quotient = 0x80000000, remainder = 0, exception = 1.
- Handshake:
  - Start pulse while busy: ignored; the original result is unchanged.
  - New start in the `data_resultRDY` cycle: accepted, next pulse exactly 34 cycles later.
  - Both ctrl lines high: multiply performed.
- `resetn` low at CALC cycle 10: outputs 0 and `data_inputRDY` = 1 immediately; no `data_resultRDY` pulse; the next operation completes correctly.
